// File: rtl/piradip_sample_buffer_pkg.sv
// Shared types and sizing helpers for the AXI-Stream sample playback engine.
// Used by piradip_axis_sample_playback and piradip_sample_prefetch_fifo.
package piradip_sample_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } playback_state_t;

    // One slot per in-flight RAM read plus two so a pop and a refill can overlap.
    function automatic int prefetch_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/piradip_sample_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched sample words. flush empties it,
// optionally keeping the current head word so a stalled beat stays intact.
module piradip_sample_prefetch_fifo
    import piradip_sample_buffer_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = prefetch_depth(1)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    input  logic                           flush,
    input  logic                           flush_keep_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_fire;
    logic             rd_fire;
    logic [DEPTH-1:0] wr_sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_fire && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        wr_fire  = wr_en && (count_q != CNT_W'(DEPTH)) && !flush;
        rd_fire  = rd_en && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            if (flush_keep_head && (count_q != '0)) begin
                wr_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = CNT_W'(1);
            end else begin
                wr_ptr_d = rd_ptr_q;
                count_d  = '0;
            end
        end else begin
            if (rd_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) entry_q[i] <= wr_data;
        end
    end

    assign rd_data = entry_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/piradip_axis_sample_playback.sv
// Streams a window of RAM words out of an AXI4-Stream manager, one-shot or looping.
// Define PIRADIP_SAMPLE_PLAYBACK_TLAST_EN to add m_axis_tlast on end-of-window beats.
module piradip_axis_sample_playback
    import piradip_sample_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  stream_update,
    input  logic                  stream_active,
    input  logic                  stream_one_shot,
    input  logic [ADDR_WIDTH-1:0] stream_start_offset,
    input  logic [ADDR_WIDTH-1:0] stream_end_offset,
    output logic                  stream_stopped,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
`ifdef PIRADIP_SAMPLE_PLAYBACK_TLAST_EN
    ,
    output logic                  m_axis_tlast
`endif
);

    localparam int DEPTH = prefetch_depth(READ_LATENCY);
    localparam int CNT_W = $clog2(DEPTH+1);

    playback_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   start_q, start_d;
    logic [ADDR_WIDTH-1:0]   end_q, end_d;
    logic                    one_shot_q, one_shot_d;
    logic                    restart_q, restart_d;
    logic                    pending_q, pending_d;
    logic [READ_LATENCY-1:0] rd_valid_q, rd_valid_d;
    logic [READ_LATENCY-1:0] rd_last_q, rd_last_d;
    logic [READ_LATENCY-1:0] stage_valid_in;
    logic [READ_LATENCY-1:0] stage_last_in;

    logic [DATA_WIDTH:0]     fifo_rd_data;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_flush;
    logic                    fifo_keep;

    logic                    issue;
    logic                    at_end;
    logic                    beat_valid;
    logic                    beat_pop;
    logic                    head_last;
    logic                    stopped;
    logic                    pipe_clear;
    int                      outstanding;
    int                      occupancy;

    // Each stage tracks one issued read and whether it targeted end_offset.
    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_valid_in[gi] = issue;
                assign stage_last_in[gi]  = at_end;
            end else begin : g_tail
                assign stage_valid_in[gi] = rd_valid_q[gi-1];
                assign stage_last_in[gi]  = rd_last_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        outstanding = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            outstanding = outstanding + int'(rd_valid_q[i]);
        end
        occupancy  = outstanding + int'(fifo_count);
        beat_valid = aresetn && !fifo_empty;
        beat_pop   = beat_valid && m_axis_tready;
        head_last  = fifo_rd_data[DATA_WIDTH];
        at_end     = (ptr_q == end_q);
        issue      = aresetn && (state_q == ST_RUN) && !pending_q && !stream_update
                     && (occupancy < DEPTH);

        state_d    = state_q;
        ptr_d      = ptr_q;
        start_d    = start_q;
        end_d      = end_q;
        one_shot_d = one_shot_q;
        restart_d  = restart_q;
        pending_d  = pending_q;
        stopped    = 1'b0;
        pipe_clear = 1'b0;
        fifo_flush = 1'b0;
        fifo_keep  = 1'b0;

        if (issue) begin
            ptr_d = at_end ? start_q : ptr_q + ADDR_WIDTH'(1);
            if (one_shot_q && at_end) state_d = ST_DRAIN;
        end

        if ((state_q == ST_DRAIN) && !pending_q && beat_pop && head_last) begin
            state_d = ST_IDLE;
            stopped = 1'b1;
        end

        if (pending_q && beat_pop) begin
            pending_d = 1'b0;
            if (restart_q) begin
                state_d = ST_RUN;
                ptr_d   = start_q;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (stream_update) begin
            if (state_q == ST_IDLE) begin
                if (stream_active) begin
                    start_d    = stream_start_offset;
                    end_d      = stream_end_offset;
                    one_shot_d = stream_one_shot;
                    state_d    = ST_RUN;
                    ptr_d      = stream_start_offset;
                end
            end else begin
                start_d    = stream_start_offset;
                end_d      = stream_end_offset;
                one_shot_d = stream_one_shot;
                pipe_clear = 1'b1;
                fifo_flush = 1'b1;
                stopped    = 1'b0;
                // A stalled beat must complete before the new window takes over.
                if (beat_valid && !m_axis_tready) begin
                    fifo_keep = 1'b1;
                    pending_d = 1'b1;
                    restart_d = stream_active;
                    state_d   = state_q;
                    ptr_d     = ptr_q;
                end else begin
                    pending_d = 1'b0;
                    state_d   = stream_active ? ST_RUN : ST_IDLE;
                    ptr_d     = stream_start_offset;
                end
            end
        end

        rd_valid_d = pipe_clear ? '0 : stage_valid_in;
        rd_last_d  = pipe_clear ? '0 : stage_last_in;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            start_q    <= '0;
            end_q      <= '0;
            one_shot_q <= 1'b0;
            restart_q  <= 1'b0;
            pending_q  <= 1'b0;
            rd_valid_q <= '0;
            rd_last_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            start_q    <= start_d;
            end_q      <= end_d;
            one_shot_q <= one_shot_d;
            restart_q  <= restart_d;
            pending_q  <= pending_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    piradip_sample_prefetch_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_prefetch (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .wr_en           (rd_valid_q[READ_LATENCY-1]),
        .wr_data         ({rd_last_q[READ_LATENCY-1], mem_rdata}),
        .rd_en           (beat_pop),
        .rd_data         (fifo_rd_data),
        .empty           (fifo_empty),
        .count           (fifo_count),
        .flush           (fifo_flush),
        .flush_keep_head (fifo_keep)
    );

    assign mem_en         = issue;
    assign mem_addr       = aresetn ? ptr_q : '0;
    assign m_axis_tvalid  = beat_valid;
    assign m_axis_tdata   = fifo_rd_data[DATA_WIDTH-1:0];
    assign stream_stopped = stopped;
`ifdef PIRADIP_SAMPLE_PLAYBACK_TLAST_EN
    assign m_axis_tlast   = beat_valid && head_last;
`endif

endmodule

// File: tb/tb_piradip_axis_sample_playback.sv
// Directed bench for piradip_axis_sample_playback: one DUT at READ_LATENCY=1, one at 3.
// Honours PIRADIP_SAMPLE_PLAYBACK_TLAST_EN when it is defined.
module tb_piradip_axis_sample_playback;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        upd = 1'b0;
    logic        act = 1'b0;
    logic        one = 1'b0;
    logic [11:0] so = '0;
    logic [11:0] eo = '0;
    logic        tready = 1'b0;

    logic [11:0] mem_addr1, mem_addr3;
    logic        mem_en1, mem_en3;
    logic [63:0] rdata1 = '0;
    logic [63:0] rdata3 = '0;
    logic [63:0] tdata1, tdata3;
    logic        tvalid1, tvalid3;
    logic        stopped1, stopped3;
`ifdef PIRADIP_SAMPLE_PLAYBACK_TLAST_EN
    logic        tlast1, tlast3;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] ram_word(input logic [11:0] a);
        return {16'hCAFE, 4'h0, a, 4'h5, a ^ 12'hA5A, 4'h0, a + 12'd1};
    endfunction

    function automatic logic [11:0] win_addr(input int base, input int len, input int n);
        return 12'(base + (n % len));
    endfunction

    piradip_axis_sample_playback #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .READ_LATENCY(1)) dut1 (
        .aclk(clk), .aresetn(aresetn), .stream_update(upd), .stream_active(act),
        .stream_one_shot(one), .stream_start_offset(so), .stream_end_offset(eo),
        .stream_stopped(stopped1), .mem_addr(mem_addr1), .mem_en(mem_en1),
        .mem_rdata(rdata1), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
        .m_axis_tready(tready)
`ifdef PIRADIP_SAMPLE_PLAYBACK_TLAST_EN
        , .m_axis_tlast(tlast1)
`endif
    );

    piradip_axis_sample_playback #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .READ_LATENCY(3)) dut3 (
        .aclk(clk), .aresetn(aresetn), .stream_update(upd), .stream_active(act),
        .stream_one_shot(one), .stream_start_offset(so), .stream_end_offset(eo),
        .stream_stopped(stopped3), .mem_addr(mem_addr3), .mem_en(mem_en3),
        .mem_rdata(rdata3), .m_axis_tdata(tdata3), .m_axis_tvalid(tvalid3),
        .m_axis_tready(tready)
`ifdef PIRADIP_SAMPLE_PLAYBACK_TLAST_EN
        , .m_axis_tlast(tlast3)
`endif
    );

    // RAM models: latency 1 and latency 3 registered read ports.
    logic [11:0] a3_1 = '0, a3_2 = '0;
    logic        e3_1 = 1'b0, e3_2 = 1'b0;
    always @(posedge clk) begin
        if (mem_en1) rdata1 <= ram_word(mem_addr1);
        a3_1 <= mem_addr3;
        e3_1 <= mem_en3;
        a3_2 <= a3_1;
        e3_2 <= e3_1;
        if (e3_2) rdata3 <= ram_word(a3_2);
    end

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        upd = 1'b0;
    endtask

    task automatic do_reset();
        begin_cycle();
        aresetn = 1'b0;
        tready  = 1'b0;
        begin_cycle();
        begin_cycle();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        begin_cycle();
        aresetn = 1'b0;
        begin_cycle();
        #3;
        compared++; if (tvalid1 !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid1: got %b expected 0", tvalid1); end
        compared++; if (mem_en1 !== 1'b0) begin mismatched++; $display("FAIL reset_mem_en1: got %b expected 0", mem_en1); end
        compared++; if (stopped1 !== 1'b0) begin mismatched++; $display("FAIL reset_stopped1: got %b expected 0", stopped1); end
        compared++; if (mem_addr1 !== 12'd0) begin mismatched++; $display("FAIL reset_mem_addr1: got %h expected 000", mem_addr1); end
        compared++; if (tvalid3 !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid3: got %b expected 0", tvalid3); end
        compared++; if (mem_en3 !== 1'b0) begin mismatched++; $display("FAIL reset_mem_en3: got %b expected 0", mem_en3); end
        begin_cycle();
        aresetn = 1'b1;
        begin_cycle();
        #3;
        compared++; if (mem_en1 !== 1'b0 || tvalid1 !== 1'b0) begin mismatched++; $display("FAIL reset_idle: got en=%b valid=%b expected 0/0", mem_en1, tvalid1); end
        $display("test_reset done");
    endtask

    task automatic test_one_shot();
        int beats = 0, reads = 0, last_c = 0, stops = 0;
        do_reset();
        begin_cycle();
        so = 12'd4; eo = 12'd7; one = 1'b1; act = 1'b1; upd = 1'b1; tready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            begin_cycle();
            #3;
            if (mem_en1) begin
                compared++;
                if (mem_addr1 !== 12'(4 + reads)) begin mismatched++; $display("FAIL oneshot_addr: got %h expected %h", mem_addr1, 12'(4 + reads)); end
                reads++;
            end
            if (stopped1) stops++;
            if (tvalid1 && tready) begin
                compared++;
                if (tdata1 !== ram_word(12'(4 + beats))) begin mismatched++; $display("FAIL oneshot_data: got %h expected %h", tdata1, ram_word(12'(4 + beats))); end
                if (beats > 0) begin
                    compared++;
                    if (c != last_c + 1) begin mismatched++; $display("FAIL oneshot_gap: got cycle %0d expected %0d", c, last_c + 1); end
                end
                compared++;
                if (stopped1 !== (beats == 3)) begin mismatched++; $display("FAIL oneshot_stopped: got %b on beat %0d", stopped1, beats); end
`ifdef PIRADIP_SAMPLE_PLAYBACK_TLAST_EN
                compared++;
                if (tlast1 !== (beats == 3)) begin mismatched++; $display("FAIL oneshot_tlast: got %b on beat %0d", tlast1, beats); end
`endif
                $display("oneshot beat %0d data %h", beats, tdata1);
                last_c = c;
                beats++;
            end
        end
        compared++; if (beats != 4) begin mismatched++; $display("FAIL oneshot_beats: got %0d expected 4", beats); end
        compared++; if (reads != 4) begin mismatched++; $display("FAIL oneshot_reads: got %0d expected 4", reads); end
        compared++; if (stops != 1) begin mismatched++; $display("FAIL oneshot_stops: got %0d expected 1", stops); end
    endtask

    task automatic test_continuous();
        int beats = 0, last_c = 0;
        logic [11:0] exp_a;
        do_reset();
        begin_cycle();
        so = 12'd0; eo = 12'd2; one = 1'b0; act = 1'b1; upd = 1'b1; tready = 1'b1;
        for (int c = 0; c < 40 && beats < 10; c++) begin
            begin_cycle();
            #3;
            compared++;
            if (stopped1 !== 1'b0) begin mismatched++; $display("FAIL cont_stopped: got %b expected 0", stopped1); end
            if (tvalid1 && tready) begin
                exp_a = win_addr(0, 3, beats);
                compared++;
                if (tdata1 !== ram_word(exp_a)) begin mismatched++; $display("FAIL cont_data: got %h expected %h", tdata1, ram_word(exp_a)); end
                if (beats > 0) begin
                    compared++;
                    if (c != last_c + 1) begin mismatched++; $display("FAIL cont_gap: got cycle %0d expected %0d", c, last_c + 1); end
                end
                $display("cont beat %0d addr %0d data %h", beats, exp_a, tdata1);
                last_c = c;
                beats++;
            end
        end
        compared++; if (beats != 10) begin mismatched++; $display("FAIL cont_beats: got %0d expected 10", beats); end
        begin_cycle();
        act = 1'b0; upd = 1'b1;
        for (int c = 0; c < 4; c++) begin_cycle();
        #3;
        compared++; if (tvalid1 !== 1'b0 || mem_en1 !== 1'b0) begin mismatched++; $display("FAIL cont_stop: got valid=%b en=%b expected 0/0", tvalid1, mem_en1); end
    endtask

    task automatic test_random_stall();
        int issued = 0, popped = 0;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        do_reset();
        begin_cycle();
        so = 12'd10; eo = 12'd20; one = 1'b0; act = 1'b1; upd = 1'b1; tready = 1'b0;
        for (int c = 0; c < 400; c++) begin
            begin_cycle();
            tready = ($urandom_range(0, 9) < 3);
            #3;
            if (mem_en3) begin
                compared++;
                if (issued - popped >= 5) begin mismatched++; $display("FAIL stall_overissue: got occupancy %0d expected <5", issued - popped); end
                compared++;
                if (mem_addr3 !== win_addr(10, 11, issued)) begin mismatched++; $display("FAIL stall_addr: got %h expected %h", mem_addr3, win_addr(10, 11, issued)); end
                issued++;
            end
            if (prev_stall) begin
                compared++;
                if (tvalid3 !== 1'b1 || tdata3 !== prev_data) begin mismatched++; $display("FAIL stall_hold: got valid=%b data=%h expected 1 %h", tvalid3, tdata3, prev_data); end
            end
            if (tvalid3 && tready) begin
                compared++;
                if (tdata3 !== ram_word(win_addr(10, 11, popped))) begin mismatched++; $display("FAIL stall_data: got %h expected %h", tdata3, ram_word(win_addr(10, 11, popped))); end
                popped++;
            end
            prev_stall = tvalid3 && !tready;
            prev_data  = tdata3;
        end
        $display("stall run issued %0d popped %0d", issued, popped);
        compared++; if (popped < 80) begin mismatched++; $display("FAIL stall_throughput: got %0d beats expected >=80", popped); end
        begin_cycle();
        tready = 1'b1; act = 1'b0; upd = 1'b1;
        for (int c = 0; c < 6; c++) begin_cycle();
    endtask

    task automatic test_mid_update();
        int exp_n = 0, n = 0;
        logic [11:0] held_a;
        logic [11:0] expect_list [4];
        do_reset();
        begin_cycle();
        so = 12'd0; eo = 12'd50; one = 1'b0; act = 1'b1; upd = 1'b1; tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            begin_cycle();
            #3;
            if (tvalid1 && tready) begin
                compared++;
                if (tdata1 !== ram_word(12'(exp_n))) begin mismatched++; $display("FAIL mid_pre_data: got %h expected %h", tdata1, ram_word(12'(exp_n))); end
                exp_n++;
            end
        end
        for (int c = 0; c < 4; c++) begin
            begin_cycle();
            tready = 1'b0;
        end
        #3;
        held_a = 12'(exp_n);
        compared++; if (tvalid1 !== 1'b1 || tdata1 !== ram_word(held_a)) begin mismatched++; $display("FAIL mid_held: got valid=%b data=%h expected 1 %h", tvalid1, tdata1, ram_word(held_a)); end
        begin_cycle();
        so = 12'd100; eo = 12'd101; act = 1'b1; upd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            begin_cycle();
            #3;
            compared++;
            if (tvalid1 !== 1'b1 || tdata1 !== ram_word(held_a)) begin mismatched++; $display("FAIL mid_hold_after_update: got valid=%b data=%h expected 1 %h", tvalid1, tdata1, ram_word(held_a)); end
        end
        expect_list[0] = held_a;
        expect_list[1] = 12'd100;
        expect_list[2] = 12'd101;
        expect_list[3] = 12'd100;
        for (int c = 0; c < 20 && n < 4; c++) begin
            begin_cycle();
            tready = 1'b1;
            #3;
            if (tvalid1 && tready) begin
                compared++;
                if (tdata1 !== ram_word(expect_list[n])) begin mismatched++; $display("FAIL mid_new_window: got %h expected %h", tdata1, ram_word(expect_list[n])); end
                $display("mid beat %0d data %h", n, tdata1);
                n++;
            end
        end
        compared++; if (n != 4) begin mismatched++; $display("FAIL mid_beats: got %0d expected 4", n); end
    endtask

    task automatic test_drain_cancel();
        int exp_n = 20, stops = 0, hs = 0, beats = 0;
        do_reset();
        begin_cycle();
        so = 12'd20; eo = 12'd23; one = 1'b1; act = 1'b1; upd = 1'b1; tready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            begin_cycle();
            #3;
            if (stopped1) stops++;
        end
        for (int c = 0; c < 2; c++) begin
            begin_cycle();
            tready = 1'b1;
            #3;
            if (stopped1) stops++;
            compared++;
            if (tvalid1 !== 1'b1 || tdata1 !== ram_word(12'(exp_n))) begin mismatched++; $display("FAIL drain_pre: got valid=%b data=%h expected 1 %h", tvalid1, tdata1, ram_word(12'(exp_n))); end
            exp_n++;
        end
        for (int c = 0; c < 3; c++) begin
            begin_cycle();
            tready = 1'b0;
            #3;
            if (stopped1) stops++;
        end
        begin_cycle();
        act = 1'b0; upd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            begin_cycle();
            #3;
            if (stopped1) stops++;
            compared++;
            if (tdata1 !== ram_word(12'(exp_n))) begin mismatched++; $display("FAIL drain_held: got %h expected %h", tdata1, ram_word(12'(exp_n))); end
        end
        for (int c = 0; c < 8; c++) begin
            begin_cycle();
            tready = 1'b1;
            #3;
            if (stopped1) stops++;
            if (tvalid1 && tready) begin
                if (hs == 0) begin
                    compared++;
                    if (tdata1 !== ram_word(12'(exp_n))) begin mismatched++; $display("FAIL drain_release: got %h expected %h", tdata1, ram_word(12'(exp_n))); end
                end
                hs++;
            end
        end
        compared++; if (hs != 1) begin mismatched++; $display("FAIL drain_beats: got %0d expected 1", hs); end
        compared++; if (stops != 0) begin mismatched++; $display("FAIL drain_stopped: got %0d pulses expected 0", stops); end
        compared++; if (mem_en1 !== 1'b0 || tvalid1 !== 1'b0) begin mismatched++; $display("FAIL drain_idle: got en=%b valid=%b expected 0/0", mem_en1, tvalid1); end
        // Single-word window in one-shot mode: exactly one beat, then stop.
        begin_cycle();
        so = 12'd5; eo = 12'd5; one = 1'b1; act = 1'b1; upd = 1'b1;
        stops = 0;
        for (int c = 0; c < 15; c++) begin
            begin_cycle();
            #3;
            if (stopped1) stops++;
            if (tvalid1 && tready) begin
                compared++;
                if (tdata1 !== ram_word(12'd5) || stopped1 !== 1'b1) begin mismatched++; $display("FAIL single_beat: got data=%h stopped=%b expected %h 1", tdata1, stopped1, ram_word(12'd5)); end
                beats++;
            end
        end
        compared++; if (beats != 1 || stops != 1) begin mismatched++; $display("FAIL single_count: got beats=%0d stops=%0d expected 1/1", beats, stops); end
    endtask

    task automatic test_reset_midrun();
        int stale = 0, n = 0;
        do_reset();
        begin_cycle();
        so = 12'd30; eo = 12'd40; one = 1'b0; act = 1'b1; upd = 1'b1; tready = 1'b1;
        for (int c = 0; c < 6; c++) begin_cycle();
        aresetn = 1'b0;
        #3;
        compared++; if (tvalid3 !== 1'b0 || mem_en3 !== 1'b0 || mem_addr3 !== 12'd0) begin mismatched++; $display("FAIL rst_during: got valid=%b en=%b addr=%h expected 0/0/000", tvalid3, mem_en3, mem_addr3); end
        begin_cycle();
        aresetn = 1'b1;
        #3;
        compared++; if (tvalid3 !== 1'b0 || mem_en3 !== 1'b0) begin mismatched++; $display("FAIL rst_after: got valid=%b en=%b expected 0/0", tvalid3, mem_en3); end
        for (int c = 0; c < 6; c++) begin
            begin_cycle();
            #3;
            if (tvalid3) stale++;
        end
        compared++; if (stale != 0) begin mismatched++; $display("FAIL rst_stale: got %0d valid cycles expected 0", stale); end
        begin_cycle();
        so = 12'd50; eo = 12'd52; one = 1'b1; act = 1'b1; upd = 1'b1;
        for (int c = 0; c < 20; c++) begin
            begin_cycle();
            #3;
            if (tvalid3 && tready) begin
                compared++;
                if (tdata3 !== ram_word(12'(50 + n)) || stopped3 !== (n == 2)) begin mismatched++; $display("FAIL rst_restart: got data=%h stopped=%b expected %h %b", tdata3, stopped3, ram_word(12'(50 + n)), n == 2); end
                n++;
            end
        end
        compared++; if (n != 3) begin mismatched++; $display("FAIL rst_restart_beats: got %0d expected 3", n); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_continuous();
        test_random_stall();
        test_mid_update();
        test_drain_cancel();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
